// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue: memory window
// defaults, the NOP used for faulted fetches, FSM encodings and the entry layout.
package instr_fetch_queue_pkg;

    localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] IMEM_LAST_DEFAULT = 32'h0100_07FC;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // 65-bit queue entry, fault flag in the MSB.
    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through queue with a synchronous flush that discards the
// same-cycle push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: captures the PC, issues one instruction-memory read at a
// time, faults out-of-window addresses, and buffers results for decode.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEFAULT,
    parameter logic [31:0] IMEM_LAST = IMEM_LAST_DEFAULT,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc_addr,
    input  logic          redirect,
    output logic          fetch_hold,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst_data,
    output logic [31:0]   inst_addr,
    output logic          inst_err,
    output fetch_state_t  dbg_state,
    output logic [CW-1:0] dbg_count
);

    // Handshakes: decode takes the head when inst_valid && inst_ready in the
    // same cycle; memory holds mem_req/mem_addr until the cycle mem_ack=1.

    fetch_state_t state;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         capture;
    logic         addr_ok;
    logic         push;
    logic         pop;
    logic         fifo_empty;
    logic         fifo_full;
    logic [CW-1:0] fifo_count;

    assign addr_ok = fetch_addr_ok(pc_addr, IMEM_BASE, IMEM_LAST);

    // Captures happen only in IDLE, so nothing is in flight and one free
    // slot is enough to guarantee the eventual push lands.
    assign capture    = !rst && (state == ST_IDLE) && !redirect && !fifo_full;
    assign fetch_hold = !capture;

    assign push = (capture && !addr_ok)
               || ((state == ST_REQ) && mem_ack && !redirect);
    assign pop  = inst_valid && inst_ready;

    always_comb begin
        push_entry = '{err: 1'b1, addr: pc_addr, data: NOP_INSTR};
        if (state == ST_REQ) begin
            push_entry = '{err: 1'b0, addr: mem_addr, data: mem_rdata};
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = head.data;
    assign inst_addr  = head.addr;
    assign inst_err   = !fifo_empty && head.err;
    assign dbg_state  = state;
    assign dbg_count  = fifo_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= IMEM_BASE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture && addr_ok) begin
                        state    <= ST_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_addr;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end else if (redirect) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory responder, scoreboard of
// expected queue entries, and explicit latency / redirect / reset steps.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_addr;
    logic         redirect;
    logic         fetch_hold;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = 32'h0;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst_data;
    logic [31:0]  inst_addr;
    logic         inst_err;
    fetch_state_t dbg_state;
    logic [2:0]   dbg_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] exp_q[$];
    bit          pc_auto  = 1'b0;
    int          resp_delay = 1;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_addr_l = 32'h0;
    int          req_rises = 0;
    bit          prev_stall = 1'b0;
    logic [64:0] prev_entry = '0;

    instr_fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .redirect   (redirect),
        .fetch_hold (fetch_hold),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_addr  (inst_addr),
        .inst_err   (inst_err),
        .dbg_state  (dbg_state),
        .dbg_count  (dbg_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0100_0000) return 32'h0050_0093;
        if (a == 32'h0100_0100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [64:0] exp_entry(input logic [31:0] a);
        if (a >= 32'h0100_0000 && a <= 32'h0100_07FC && a[1:0] == 2'b00)
            return {1'b0, a, mem_fn(a)};
        return {1'b1, a, 32'h0000_0013};
    endfunction

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: note whether a capture or flush happens, then update the model.
    task automatic tick();
        bit cap;
        bit flushed;
        #2;
        cap     = (fetch_hold === 1'b0);
        flushed = (redirect === 1'b1) || (rst === 1'b1);
        @(posedge clk);
        #1;
        if (flushed) exp_q.delete();
        if (cap) begin
            exp_q.push_back(exp_entry(pc_addr));
            if (pc_auto) pc_addr = pc_addr + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect = 1'b1;
        pc_addr  = target;
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_capture(input string tag);
        int n;
        n = 0;
        #1;
        while (fetch_hold !== 1'b0 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk(tag, 65'(fetch_hold), 65'd0);
    endtask

    // Memory model: ack resp_delay cycles after mem_req is first seen.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (busy) begin
            if (mem_req === 1'b1 && rst === 1'b0)
                chk("mem_addr_stable", 65'(mem_addr), 65'(req_addr_l));
            if (cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(req_addr_l);
                busy      = 1'b0;
            end else begin
                cnt--;
            end
        end else if (mem_req === 1'b1) begin
            req_rises++;
            req_addr_l = mem_addr;
            if (resp_delay == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
            end else begin
                busy = 1'b1;
                cnt  = resp_delay - 1;
            end
        end
    end

    // Scoreboard: compare each accepted instruction, and hold-stability on stalls.
    always @(negedge clk) begin
        logic [64:0] e;
        logic [64:0] cur;
        cur = {inst_err, inst_addr, inst_data};
        if (prev_stall && inst_valid === 1'b1)
            chk("stall_stable", cur, prev_entry);
        if (inst_valid === 1'b1 && inst_ready === 1'b1 && redirect === 1'b0 && rst === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL pop_underflow: got %h expected no entry", cur);
            end else begin
                e = exp_q.pop_front();
                chk("pop_entry", cur, e);
            end
        end
        prev_stall = (inst_valid === 1'b1) && (inst_ready === 1'b0)
                  && (redirect === 1'b0) && (rst === 1'b0);
        prev_entry = cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises_before;
        rst        = 1'b1;
        redirect   = 1'b0;
        inst_ready = 1'b1;
        pc_addr    = 32'h0100_0000;
        pc_auto    = 1'b1;
        resp_delay = 1;
        @(posedge clk);
        #1;
        run(3);

        // Reset values
        chk("rst_mem_req",    65'(mem_req),    65'd0);
        chk("rst_mem_addr",   65'(mem_addr),   65'(32'h0100_0000));
        chk("rst_inst_valid", 65'(inst_valid), 65'd0);
        chk("rst_fetch_hold", 65'(fetch_hold), 65'd1);
        chk("rst_inst_err",   65'(inst_err),   65'd0);
        chk("rst_state",      65'(dbg_state),  65'(ST_IDLE));
        chk("rst_count",      65'(dbg_count),  65'd0);

        // First fetch latency
        rst = 1'b0;
        #1;
        chk("first_capture", 65'(fetch_hold), 65'd0);
        tick();
        chk("n1_mem_req",    65'(mem_req),    65'd1);
        chk("n1_mem_addr",   65'(mem_addr),   65'(32'h0100_0000));
        chk("n1_inst_valid", 65'(inst_valid), 65'd0);
        chk("n1_state",      65'(dbg_state),  65'(ST_REQ));
        tick();
        chk("n2_mem_req",    65'(mem_req),    65'd1);
        chk("n2_inst_valid", 65'(inst_valid), 65'd0);
        tick();
        chk("n3_inst_valid", 65'(inst_valid), 65'd1);
        chk("n3_head", {inst_err, inst_addr, inst_data}, {1'b0, 32'h0100_0000, 32'h0050_0093});
        chk("n3_mem_req",    65'(mem_req),    65'd0);
        run(20);

        // Fill with decode stalled
        inst_ready = 1'b0;
        resp_delay = 0;
        run(20);
        chk("full_count",  65'(dbg_count),    65'd4);
        chk("full_model",  65'(exp_q.size()), 65'd4);
        chk("full_hold",   65'(fetch_hold),   65'd1);
        chk("full_req",    65'(mem_req),      65'd0);
        rises_before = req_rises;
        run(10);
        chk("full_no_issue", 65'(req_rises), 65'(rises_before));

        // Pop one, then push and pop in the same cycle
        resp_delay = 2;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        chk("refill_req",   65'(mem_req),   65'd1);
        chk("refill_count", 65'(dbg_count), 65'd3);
        tick();
        tick();
        chk("pp_count_before", 65'(dbg_count), 65'd3);
        inst_ready = 1'b1;
        tick();
        chk("pp_count_after", 65'(dbg_count),  65'd3);
        chk("pp_valid",       65'(inst_valid), 65'd1);
        resp_delay = 0;
        run(30);

        // Out-of-window fetch
        resp_delay = 1;
        pc_auto    = 1'b0;
        do_redirect(32'h0100_0800);
        wait_capture("oob_capture");
        tick();
        chk("oob_no_req", 65'(mem_req),    65'd0);
        chk("oob_valid",  65'(inst_valid), 65'd1);
        chk("oob_head", {inst_err, inst_addr, inst_data}, {1'b1, 32'h0100_0800, 32'h0000_0013});
        run(4);
        pc_auto = 1'b1;
        do_redirect(32'h0100_07F8);
        run(12);
        pc_auto = 1'b0;
        do_redirect(32'h0100_0002);
        run(6);
        do_redirect(32'h00FF_FFFC);
        run(6);

        // Redirect with a request outstanding
        resp_delay = 4;
        do_redirect(32'h0100_0100);
        wait_capture("disc_capture");
        tick();
        chk("disc_req",  65'(mem_req),  65'd1);
        chk("disc_addr", 65'(mem_addr), 65'(32'h0100_0100));
        redirect = 1'b1;
        pc_addr  = 32'h0100_0200;
        tick();
        redirect = 1'b0;
        chk("disc_state", 65'(dbg_state), 65'(ST_DISCARD));
        chk("disc_req_held", 65'(mem_req), 65'd1);
        tick();
        chk("disc_hold", 65'(fetch_hold), 65'd1);
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("disc_redirect_again", 65'(dbg_state), 65'(ST_DISCARD));
        tick();
        chk("disc_ack_cycle_req", 65'(mem_req),    65'd1);
        chk("disc_ack_cycle_val", 65'(inst_valid), 65'd0);
        tick();
        chk("disc_done_req",   65'(mem_req),    65'd0);
        chk("disc_done_valid", 65'(inst_valid), 65'd0);
        chk("disc_done_state", 65'(dbg_state),  65'(ST_IDLE));
        chk("disc_done_count", 65'(dbg_count),  65'd0);
        chk("disc_next_cap",   65'(fetch_hold), 65'd0);
        pc_auto    = 1'b1;
        resp_delay = 1;
        run(10);

        // Redirect in the same cycle as the ack
        pc_auto = 1'b0;
        do_redirect(32'h0100_0300);
        wait_capture("same_capture");
        tick();
        chk("same_req", 65'(mem_req), 65'd1);
        tick();
        redirect = 1'b1;
        pc_addr  = 32'h0100_0400;
        tick();
        redirect = 1'b0;
        #1;
        chk("same_state", 65'(dbg_state),  65'(ST_IDLE));
        chk("same_req_d", 65'(mem_req),    65'd0);
        chk("same_valid", 65'(inst_valid), 65'd0);
        chk("same_count", 65'(dbg_count),  65'd0);
        chk("same_cap",   65'(fetch_hold), 65'd0);
        run(10);

        // Reset during a request, stray ack afterwards
        do_redirect(32'h0100_0500);
        wait_capture("rst_capture");
        tick();
        chk("rstreq_req", 65'(mem_req), 65'd1);
        rst = 1'b1;
        tick();
        chk("rstreq_mem_req", 65'(mem_req),    65'd0);
        chk("rstreq_valid",   65'(inst_valid), 65'd0);
        chk("rstreq_hold",    65'(fetch_hold), 65'd1);
        chk("rstreq_state",   65'(dbg_state),  65'(ST_IDLE));
        rst     = 1'b0;
        pc_addr = 32'h0100_0600;
        tick();
        chk("stray_valid", 65'(inst_valid), 65'd0);
        chk("stray_count", 65'(dbg_count),  65'd0);
        chk("stray_req",   65'(mem_req),    65'd1);
        chk("stray_addr",  65'(mem_addr),   65'(32'h0100_0600));
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
